mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined datapath.
- Data requests have priority by default, because a pending data access stalls the whole pipeline.
- A starvation counter guarantees fetch progress.
- A watchdog aborts any RAM access that never completes and flags it.

Parameters:
STARVE_LIMIT, 4, number of consecutive cycles a pending fetch may lose arbitration before fetch is forced to win.
TIMEOUT_CYCLES, 64, maximum cycles a granted access may wait for ramready before it is aborted.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
iREN  in  1  instruction read request; held high until ihit.
iaddr  in  32  instruction address.
ihit  out  1  fetch complete this cycle; iload valid.
iload  out  32  instruction read data.
dREN  in  1  data read request.
dWEN  in  1  data write request; wins over dREN if both are high.
daddr  in  32  data address.
dstore  in  32  data write value.
dhit  out  1  data access complete this cycle; dload valid for reads.
dload  out  32  data read value.
ramREN  out  1  RAM read strobe.
ramWEN  out  1  RAM write strobe.
ramaddr  out  32  RAM address.
ramstore  out  32  RAM write data.
ramload  in  32  RAM read data.
ramready  in  1  RAM completes the current access this cycle.
timeout  out  1  one-cycle pulse when an access is aborted by the watchdog.
busy  out  1  high in any grant state.

Behaviour:
- States: IDLE, IGRANT, DGRANT.
- Reset:
  - state=IDLE.
  - Starvation counter, watchdog counter, latched address/data/write-flag all 0.
  - All outputs 0.
- IDLE arbitration (registered, evaluated every IDLE cycle):
  - Starvation condition: iREN=1 and starve_cnt>=STARVE_LIMIT.
  - If the starvation condition holds -> IGRANT.
  - Else if dREN|dWEN -> DGRANT.
  - Else if iREN -> IGRANT.
  - Else stay in IDLE.
- Latching on grant entry:
  - DGRANT latches daddr, dstore and wr=dWEN.
  - IGRANT latches iaddr.
- RAM drive:
  - In IDLE, all ram* outputs are 0.
  - In DGRANT: ramaddr=latched daddr; ramWEN=wr; ramREN=~wr; ramstore=latched dstore.
  - In IGRANT: ramaddr=latched iaddr; ramREN=1; ramWEN=0; ramstore=0.
- Completion (combinational in the grant state):
  - ihit=(IGRANT & ramready & iREN).
  - dhit=(DGRANT & ramready & (dREN|dWEN)).
  - iload=ramload while in IGRANT, else 0.
  - dload=ramload while in DGRANT & ~wr, else 0.
  - On completion, next state is IDLE.
  - Minimum latency from request to hit is 2 cycles: one IDLE cycle to arbitrate, one grant cycle with ramready=1.
  - Back-to-back accesses always have one IDLE bubble between them.
- Request withdrawal: if the granted requester drops its request before ramready, go to IDLE next cycle with no hit.
- Watchdog:
  - wd_cnt clears on grant entry and increments each grant cycle with ramready=0.
  - When wd_cnt==TIMEOUT_CYCLES-1 and ramready=0: timeout=1 for that cycle, next state is IDLE, no hit.
  - The requester re-arbitrates normally afterwards.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments each cycle with iREN=1 and state!=IGRANT.
  - Clears when IGRANT is entered or iREN=0.
- busy=(state!=IDLE).
- Reset asserted mid-access: immediate return to IDLE with all outputs 0; no hit is issued for the aborted access.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40, ramready=1 with ramload=0x8C220004 in the grant cycle -> ramREN=1, ramaddr=0x40 in cycle 2; ihit=1, iload=0x8C220004 the same cycle; busy=0 in cycle 3.
- Contention: iREN=dREN=1 from reset, daddr=0x100 -> DGRANT first, ramaddr=0x100; then IGRANT after one IDLE bubble.
- Starvation: dWEN held high with back-to-back accesses completing, iREN=1 -> after the 4th cycle of fetch loss, IGRANT wins while dWEN is still high; ihit is issued.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramready high after 3 cycles -> ramWEN=1, ramREN=0 throughout; dhit=1 exactly once; dload=0.
- Watchdog: TIMEOUT_CYCLES=8, ramready=0 forever, dREN=1 -> timeout pulse in the 8th grant cycle; IDLE next cycle; re-grant follows; no dhit.
- Reset and withdrawal: RST asserted in the middle of DGRANT -> all outputs 0 immediately. Separately, dREN dropped mid-grant -> IDLE next cycle, no dhit.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-port signals around the fetch/data memory arbiter.
// The slave modport is the arbiter's view; the master modport is the datapath/RAM side.
interface mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramready;
    logic        timeout;
    logic        busy;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, timeout, busy
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, timeout, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins by default; a starvation counter forces fetch through, a watchdog aborts hung accesses.
module mem_arbiter #(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave mif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SW-1:0] SLIM    = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    state_t        state, nxt;
    logic [SW-1:0] starve_cnt;
    logic [WW-1:0] wd_cnt;
    logic [31:0]   addr_q;
    logic [31:0]   store_q;
    logic          wr_q;

    logic          d_req, starve, wd_fire;
    logic          ihit_c, dhit_c, timeout_c;
    logic          ram_ren_c, ram_wen_c;
    logic [31:0]   ram_addr_c, ram_store_c, iload_c, dload_c;

    assign d_req   = mif.dREN | mif.dWEN;
    assign starve  = mif.iREN && (starve_cnt >= SLIM);
    assign wd_fire = (wd_cnt == WD_LAST) && !mif.ramready;

    always_comb begin
        nxt       = state;
        ihit_c    = 1'b0;
        dhit_c    = 1'b0;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (starve)         nxt = IGRANT;
                else if (d_req)     nxt = DGRANT;
                else if (mif.iREN)  nxt = IGRANT;
            end
            IGRANT: begin
                ihit_c = mif.ramready & mif.iREN;
                if (mif.ramready) begin
                    nxt = IDLE;
                end else if (wd_fire) begin
                    nxt       = IDLE;
                    timeout_c = 1'b1;
                end else if (!mif.iREN) begin
                    nxt = IDLE;
                end
            end
            DGRANT: begin
                dhit_c = mif.ramready & d_req;
                if (mif.ramready) begin
                    nxt = IDLE;
                end else if (wd_fire) begin
                    nxt       = IDLE;
                    timeout_c = 1'b1;
                end else if (!d_req) begin
                    nxt = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // RAM drive and load paths decode purely from the registered state,
    // so an asynchronous reset zeroes them without waiting for a clock.
    always_comb begin
        ram_ren_c   = 1'b0;
        ram_wen_c   = 1'b0;
        ram_addr_c  = '0;
        ram_store_c = '0;
        iload_c     = '0;
        dload_c     = '0;
        case (state)
            IGRANT: begin
                ram_ren_c  = 1'b1;
                ram_addr_c = addr_q;
                iload_c    = mif.ramload;
            end
            DGRANT: begin
                ram_ren_c   = ~wr_q;
                ram_wen_c   = wr_q;
                ram_addr_c  = addr_q;
                ram_store_c = store_q;
                dload_c     = wr_q ? 32'h0 : mif.ramload;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            wd_cnt     <= '0;
            addr_q     <= '0;
            store_q    <= '0;
            wr_q       <= 1'b0;
        end else begin
            state <= nxt;

            if (state == IDLE && nxt == DGRANT) begin
                addr_q  <= mif.daddr;
                store_q <= mif.dstore;
                wr_q    <= mif.dWEN;
            end else if (state == IDLE && nxt == IGRANT) begin
                addr_q  <= mif.iaddr;
                store_q <= '0;
                wr_q    <= 1'b0;
            end

            if (state == IDLE)
                wd_cnt <= '0;
            else if (!mif.ramready)
                wd_cnt <= wd_cnt + 1'b1;

            // Counts fetch-pending cycles spent outside IGRANT; saturates at the limit.
            if (!mif.iREN || (state == IDLE && nxt == IGRANT))
                starve_cnt <= '0;
            else if (state != IGRANT && starve_cnt < SLIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign mif.ihit     = ihit_c;
    assign mif.dhit     = dhit_c;
    assign mif.iload    = iload_c;
    assign mif.dload    = dload_c;
    assign mif.ramREN   = ram_ren_c;
    assign mif.ramWEN   = ram_wen_c;
    assign mif.ramaddr  = ram_addr_c;
    assign mif.ramstore = ram_store_c;
    assign mif.timeout  = timeout_c;
    assign mif.busy     = (state != IDLE);

    a_strobe_excl: assert property (@(posedge CLK) disable iff (RST) !(mif.ramREN && mif.ramWEN));
    a_hit_excl:    assert property (@(posedge CLK) disable iff (RST) !(mif.ihit && mif.dhit));
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, starvation, write, watchdog, reset, withdrawal.
module tb_mem_arbiter;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   dhit_seen;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .mif (bus)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramload  = '0;
        bus.ramready = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    initial begin
        clr_in();
        #12;
        // reset state
        chk("rst_busy",    32'(bus.busy),    32'h0);
        chk("rst_ramREN",  32'(bus.ramREN),  32'h0);
        chk("rst_ramWEN",  32'(bus.ramWEN),  32'h0);
        chk("rst_ramaddr", bus.ramaddr,      32'h0);
        chk("rst_ihit",    32'(bus.ihit),    32'h0);
        chk("rst_timeout", 32'(bus.timeout), 32'h0);
        do_reset();

        // single fetch
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        #1 chk("f_arb_busy", 32'(bus.busy), 32'h0);
        tick();
        bus.ramready = 1'b1; bus.ramload = 32'h8C220004;
        #1;
        chk("f_ramREN",  32'(bus.ramREN), 32'h1);
        chk("f_ramWEN",  32'(bus.ramWEN), 32'h0);
        chk("f_ramaddr", bus.ramaddr,     32'h40);
        chk("f_ihit",    32'(bus.ihit),   32'h1);
        chk("f_iload",   bus.iload,       32'h8C220004);
        chk("f_dhit",    32'(bus.dhit),   32'h0);
        tick();
        clr_in();
        #1;
        chk("f_done_busy", 32'(bus.busy), 32'h0);
        chk("f_done_ihit", 32'(bus.ihit), 32'h0);

        // contention: data first, then fetch after one bubble
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        bus.ramready = 1'b1; bus.ramload = 32'h11112222;
        tick();
        #1;
        chk("c_d_ramaddr", bus.ramaddr,   32'h100);
        chk("c_d_dhit",    32'(bus.dhit), 32'h1);
        chk("c_d_dload",   bus.dload,     32'h11112222);
        chk("c_d_ihit",    32'(bus.ihit), 32'h0);
        chk("c_d_iload",   bus.iload,     32'h0);
        tick();
        bus.dREN = 1'b0;
        #1 chk("c_bubble_busy", 32'(bus.busy), 32'h0);
        tick();
        #1;
        chk("c_i_ramaddr", bus.ramaddr,   32'h44);
        chk("c_i_ihit",    32'(bus.ihit), 32'h1);
        chk("c_i_iload",   bus.iload,     32'h11112222);
        tick();
        clr_in();

        // starvation: two data writes complete, then fetch is forced in
        do_reset();
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        bus.dWEN = 1'b1; bus.daddr = 32'h300; bus.dstore = 32'h12345678;
        bus.ramready = 1'b1;
        tick();
        #1 chk("s_d1_dhit", 32'(bus.dhit), 32'h1);
        chk("s_d1_ramWEN", 32'(bus.ramWEN), 32'h1);
        tick();
        #1 chk("s_b1_busy", 32'(bus.busy), 32'h0);
        tick();
        #1 chk("s_d2_dhit", 32'(bus.dhit), 32'h1);
        tick();
        #1 chk("s_b2_busy", 32'(bus.busy), 32'h0);
        tick();
        #1;
        chk("s_i_ramaddr", bus.ramaddr,     32'h80);
        chk("s_i_ramREN",  32'(bus.ramREN), 32'h1);
        chk("s_i_ramWEN",  32'(bus.ramWEN), 32'h0);
        chk("s_i_ihit",    32'(bus.ihit),   32'h1);
        chk("s_i_dhit",    32'(bus.dhit),   32'h0);
        tick();
        clr_in();

        // write with ramready arriving in the 3rd grant cycle
        do_reset();
        dhit_seen = 0;
        bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
        bus.ramload = 32'hCAFEF00D;
        for (int g = 1; g <= 3; g++) begin
            tick();
            bus.ramready = (g == 3);
            #1;
            chk($sformatf("w_ramWEN_%0d", g),   32'(bus.ramWEN), 32'h1);
            chk($sformatf("w_ramREN_%0d", g),   32'(bus.ramREN), 32'h0);
            chk($sformatf("w_ramaddr_%0d", g),  bus.ramaddr,     32'h200);
            chk($sformatf("w_ramstore_%0d", g), bus.ramstore,    32'hDEADBEEF);
            chk($sformatf("w_dload_%0d", g),    bus.dload,       32'h0);
            if (bus.dhit) dhit_seen++;
        end
        tick();
        bus.dWEN = 1'b0; bus.ramready = 1'b0;
        #1;
        if (bus.dhit) dhit_seen++;
        chk("w_dhit_count", 32'(dhit_seen), 32'h1);
        chk("w_after_busy", 32'(bus.busy),  32'h0);
        chk("w_after_wen",  32'(bus.ramWEN), 32'h0);

        // watchdog: ramready never arrives
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h400;
        for (int g = 1; g <= 8; g++) begin
            tick();
            #1;
            chk($sformatf("wd_timeout_%0d", g), 32'(bus.timeout), 32'(g == 8));
            chk($sformatf("wd_dhit_%0d", g),    32'(bus.dhit),    32'h0);
            chk($sformatf("wd_busy_%0d", g),    32'(bus.busy),    32'h1);
        end
        tick();
        #1;
        chk("wd_idle_busy",    32'(bus.busy),    32'h0);
        chk("wd_idle_timeout", 32'(bus.timeout), 32'h0);
        tick();
        #1;
        chk("wd_regrant_busy", 32'(bus.busy), 32'h1);
        chk("wd_regrant_addr", bus.ramaddr,   32'h400);

        // withdrawal: drop dREN in the second grant cycle
        tick();
        bus.dREN = 1'b0;
        #1 chk("wdr_dhit", 32'(bus.dhit), 32'h0);
        tick();
        #1;
        chk("wdr_busy", 32'(bus.busy), 32'h0);
        chk("wdr_dhit_after", 32'(bus.dhit), 32'h0);

        // reset in the middle of a data grant
        do_reset();
        bus.dREN = 1'b1; bus.daddr = 32'h500;
        tick();
        bus.ramready = 1'b1; bus.ramload = 32'h55AA55AA;
        #1;
        chk("r_pre_dhit",   32'(bus.dhit),   32'h1);
        chk("r_pre_ramREN", 32'(bus.ramREN), 32'h1);
        #1 RST = 1'b1;
        #1;
        chk("r_busy",    32'(bus.busy),   32'h0);
        chk("r_ramREN",  32'(bus.ramREN), 32'h0);
        chk("r_ramaddr", bus.ramaddr,     32'h0);
        chk("r_dhit",    32'(bus.dhit),   32'h0);
        chk("r_dload",   bus.dload,       32'h0);
        clr_in();
        tick();
        RST = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
